// File: rtl/pos_func_sweeper.sv
// ============================================================================
// Module   : pos_func_sweeper
// Brief    : N-input Boolean function evaluator driven by a maxterm mask.
//            It sweeps all input vectors or evaluates one supplied vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pos_func_sweeper #(
  parameter  int N_IN = 4,
  localparam int TT_W = 2**N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [TT_W-1:0]   cfg_mask_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [N_IN-1:0]   single_in_i,
  output logic              busy_o,
  output logic [N_IN-1:0]   vec_out_o,
  output logic              f_out_o,
  output logic              f_valid_o,
  output logic              done_o,
  output logic [N_IN:0]     ones_cnt_o,
  output logic [TT_W-1:0]   result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN-1:0] VEC_MAX = '1;

  state_t            state_q, state_d;
  logic [TT_W-1:0]   mask_q, mask_d;
  logic              mode_q, mode_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              f_q, f_d;
  logic              f_valid_q, f_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic [TT_W-1:0]   result_q, result_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      vec_q     <= '0;
      f_q       <= 1'b0;
      f_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ones_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      vec_q     <= vec_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ones_q    <= ones_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    vec_d     = vec_q;
    f_d       = f_q;
    f_valid_d = 1'b0;
    done_d    = 1'b0;
    ones_d    = ones_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we_i) begin
          mask_d = cfg_mask_i;
        end
        // mask_d already carries a same-cycle write, so the first vector uses it
        if (start_i) begin
          mode_d    = mode_i;
          vec_d     = mode_i ? single_in_i : '0;
          f_d       = ~mask_d[vec_d];
          f_valid_d = 1'b1;
          ones_d    = '0;
          result_d  = '0;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        result_d[vec_q] = f_q;
        ones_d          = ones_q + {{N_IN{1'b0}}, f_q};
        if (!mode_q && (vec_q != VEC_MAX)) begin
          vec_d     = vec_q + VEC_ONE;
          f_d       = ~mask_q[vec_d];
          f_valid_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy_o     = busy_q;
  assign vec_out_o  = vec_q;
  assign f_out_o    = f_q;
  assign f_valid_o  = f_valid_q;
  assign done_o     = done_q;
  assign ones_cnt_o = ones_q;
  assign result_o   = result_q;

endmodule

`default_nettype wire
